// File: rtl/aso_input_pkg.sv
// Shared types and bit positions for the Alpha Mission input conditioning stage.
package aso_input_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } coin_state_t;

  localparam int NUM_BTN = 10;

  // Raw joystick bit positions (active high)
  localparam int JOY_R       = 0;
  localparam int JOY_L       = 1;
  localparam int JOY_D       = 2;
  localparam int JOY_U       = 3;
  localparam int JOY_FIRE    = 4;
  localparam int JOY_MISSILE = 5;
  localparam int JOY_ARMOR   = 6;
  localparam int JOY_START   = 7;
  localparam int JOY_COIN    = 8;
  localparam int JOY_AUTO    = 9;

  // PLAYER1 bit positions (active low)
  localparam int P1_COIN    = 0;
  localparam int P1_START   = 1;
  localparam int P1_FIRE    = 2;
  localparam int P1_MISSILE = 3;
  localparam int P1_ARMOR   = 4;
  localparam int P1_SERVICE = 9;
  localparam int P1_L       = 10;
  localparam int P1_R       = 11;
  localparam int P1_D       = 12;
  localparam int P1_U       = 13;

  localparam logic [15:0] P1_ONES_MASK = 16'hC1E0;

endpackage

// File: rtl/aso_debounce.sv
// Single-channel debouncer; the input must already be synchronised to clk_i.
module aso_debounce #(
  parameter int unsigned DEB_CYCLES = 53600
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic din_i,
  output logic dout_o
);

  localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          state_q, state_d;

  // Any sample that agrees with the current state restarts the stability window
  always_comb begin
    cnt_d   = '0;
    state_d = state_q;
    if (din_i != state_q) begin
      if (cnt_q == CW'(DEB_CYCLES - 1)) begin
        state_d = ~state_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      state_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign dout_o = state_q;

endmodule

// File: rtl/aso_input_ctrl.sv
// Joystick/service conditioning into the active-low PLAYER1 word, with coin pulse shaping.
// Optional autofire is built only when ASO_AUTOFIRE_EN is defined.
module aso_input_ctrl
  import aso_input_pkg::*;
#(
  parameter int unsigned DEB_CYCLES        = 53600,
  parameter int unsigned COIN_PULSE_CYCLES = 5360000,
  parameter int unsigned COIN_GAP_CYCLES   = 2680000,
  parameter int unsigned AUTOFIRE_HALF     = 1340000
) (
  input  logic        i_clk,
  input  logic        RESETn,
  input  logic [15:0] joystick,
  input  logic        service_n,
  input  logic        flip,
  output logic [15:0] PLAYER1,
  output logic        coin_busy
);

  localparam int unsigned CMAX = (COIN_PULSE_CYCLES > COIN_GAP_CYCLES) ?
                                 COIN_PULSE_CYCLES : COIN_GAP_CYCLES;
  localparam int unsigned CCW  = $clog2(CMAX + 1);

  logic [NUM_BTN-1:0] joy_s1_q, joy_s2_q, deb;
  logic               svc_s1_q, svc_s2_q;
  logic               unused_hi;

  assign unused_hi = ^joystick[15:10];

  // Service idles high so the output stays all-ones coming out of reset
  always_ff @(posedge i_clk or negedge RESETn) begin
    if (!RESETn) begin
      joy_s1_q <= '0;
      joy_s2_q <= '0;
      svc_s1_q <= 1'b1;
      svc_s2_q <= 1'b1;
    end else begin
      joy_s1_q <= joystick[NUM_BTN-1:0];
      joy_s2_q <= joy_s1_q;
      svc_s1_q <= service_n;
      svc_s2_q <= svc_s1_q;
    end
  end

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_deb
    aso_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk_i  (i_clk),
      .rst_ni (RESETn),
      .din_i  (joy_s2_q[g]),
      .dout_o (deb[g])
    );
  end

  logic fire_eff;
`ifdef ASO_AUTOFIRE_EN
  localparam int unsigned AW = $clog2(AUTOFIRE_HALF + 1);
  logic [AW-1:0] af_cnt_q;
  logic          af_phase_q;

  always_ff @(posedge i_clk or negedge RESETn) begin
    if (!RESETn) begin
      af_cnt_q   <= '0;
      af_phase_q <= 1'b1;
    end else if (af_cnt_q == AW'(AUTOFIRE_HALF - 1)) begin
      af_cnt_q   <= '0;
      af_phase_q <= ~af_phase_q;
    end else begin
      af_cnt_q   <= af_cnt_q + AW'(1);
    end
  end

  assign fire_eff = deb[JOY_FIRE] | (deb[JOY_AUTO] & af_phase_q);
`else
  logic unused_af;
  assign unused_af = deb[JOY_AUTO] ^ AUTOFIRE_HALF[0];
  assign fire_eff  = deb[JOY_FIRE];
`endif

  logic up_f, dn_f, lt_f, rt_f, up_c, dn_c, lt_c, rt_c;

  // Flip first, then cancel opposing pairs in screen orientation
  always_comb begin
    up_f = flip ? deb[JOY_D] : deb[JOY_U];
    dn_f = flip ? deb[JOY_U] : deb[JOY_D];
    lt_f = flip ? deb[JOY_R] : deb[JOY_L];
    rt_f = flip ? deb[JOY_L] : deb[JOY_R];
    up_c = up_f & ~dn_f;
    dn_c = dn_f & ~up_f;
    lt_c = lt_f & ~rt_f;
    rt_c = rt_f & ~lt_f;
  end

  coin_state_t    coin_state_q, coin_state_d;
  logic [CCW-1:0] coin_cnt_q, coin_cnt_d;
  logic           coin_prev_q, coin_rise;

  assign coin_rise = deb[JOY_COIN] & ~coin_prev_q;

  // Rises outside IDLE are dropped; coin_prev_q tracks every cycle so nothing is queued
  always_comb begin
    coin_state_d = coin_state_q;
    coin_cnt_d   = coin_cnt_q;
    case (coin_state_q)
      IDLE: if (coin_rise) begin
        coin_state_d = PULSE;
        coin_cnt_d   = CCW'(COIN_PULSE_CYCLES - 1);
      end
      PULSE: if (coin_cnt_q == '0) coin_state_d = HOLD;
             else coin_cnt_d = coin_cnt_q - CCW'(1);
      HOLD: if (!deb[JOY_COIN]) begin
        coin_state_d = GAP;
        coin_cnt_d   = CCW'(COIN_GAP_CYCLES - 1);
      end
      GAP: if (coin_cnt_q == '0) coin_state_d = IDLE;
           else coin_cnt_d = coin_cnt_q - CCW'(1);
      default: coin_state_d = IDLE;
    endcase
  end

  logic [15:0] p1_d, p1_q;
  logic        coin_busy_q;

  always_comb begin
    p1_d             = P1_ONES_MASK;
    p1_d[P1_U]       = ~up_c;
    p1_d[P1_D]       = ~dn_c;
    p1_d[P1_R]       = ~rt_c;
    p1_d[P1_L]       = ~lt_c;
    p1_d[P1_SERVICE] = svc_s2_q;
    p1_d[P1_ARMOR]   = ~deb[JOY_ARMOR];
    p1_d[P1_MISSILE] = ~deb[JOY_MISSILE];
    p1_d[P1_FIRE]    = ~fire_eff;
    p1_d[P1_START]   = ~deb[JOY_START];
    p1_d[P1_COIN]    = (coin_state_d != PULSE);
  end

  always_ff @(posedge i_clk or negedge RESETn) begin
    if (!RESETn) begin
      coin_state_q <= IDLE;
      coin_cnt_q   <= '0;
      coin_prev_q  <= 1'b0;
      coin_busy_q  <= 1'b0;
      p1_q         <= 16'hFFFF;
    end else begin
      coin_state_q <= coin_state_d;
      coin_cnt_q   <= coin_cnt_d;
      coin_prev_q  <= deb[JOY_COIN];
      coin_busy_q  <= (coin_state_d != IDLE);
      p1_q         <= p1_d;
    end
  end

  assign PLAYER1   = p1_q;
  assign coin_busy = coin_busy_q;

endmodule

// File: tb/tb_aso_input_ctrl.sv
// Self-checking bench for aso_input_ctrl with a cycle-level behavioural reference model.
module tb_aso_input_ctrl;

  localparam int DEB   = 4;
  localparam int PULSE = 8;
  localparam int GAPC  = 4;
  localparam int AFH   = 3;

  logic        i_clk = 1'b0;
  logic        RESETn;
  logic [15:0] joystick;
  logic        service_n;
  logic        flip;
  logic [15:0] PLAYER1;
  logic        coin_busy;

  int vectors     = 0;
  int miscompares = 0;

  aso_input_ctrl #(
    .DEB_CYCLES       (DEB),
    .COIN_PULSE_CYCLES(PULSE),
    .COIN_GAP_CYCLES  (GAPC),
    .AUTOFIRE_HALF    (AFH)
  ) dut (
    .i_clk    (i_clk),
    .RESETn   (RESETn),
    .joystick (joystick),
    .service_n(service_n),
    .flip     (flip),
    .PLAYER1  (PLAYER1),
    .coin_busy(coin_busy)
  );

  always #5 i_clk = ~i_clk;

  // Reference model state
  bit          m_deb [10];
  int          m_run [10];
  logic [9:0]  m_s1, m_s2;
  logic        m_v1, m_v2;
  bit          m_prev, m_hold;
  int          m_pulse, m_gap, m_n;
  logic [15:0] exp_p1;
  logic        exp_busy;

  int   lows, falls;
  logic last0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 10; i++) begin
      m_deb[i] = 1'b0;
      m_run[i] = 0;
    end
    m_s1 = '0; m_s2 = '0; m_v1 = 1'b1; m_v2 = 1'b1;
    m_prev = 1'b0; m_hold = 1'b0; m_pulse = 0; m_gap = 0; m_n = 0;
    exp_p1 = 16'hFFFF; exp_busy = 1'b0;
  endtask

  // One clock edge: outputs come from the conditions present before the edge
  task automatic model_step();
    bit u, d, l, r, fire, idle;
    u = flip ? m_deb[2] : m_deb[3];
    d = flip ? m_deb[3] : m_deb[2];
    r = flip ? m_deb[1] : m_deb[0];
    l = flip ? m_deb[0] : m_deb[1];
    if (u && d) begin u = 1'b0; d = 1'b0; end
    if (l && r) begin l = 1'b0; r = 1'b0; end
    fire = m_deb[4];
`ifdef ASO_AUTOFIRE_EN
    if (m_deb[9] && (((m_n / AFH) % 2) == 0)) fire = 1'b1;
`endif
    idle = (m_pulse == 0) && !m_hold && (m_gap == 0);
    if (idle) begin
      if (m_deb[8] && !m_prev) m_pulse = PULSE;
    end else if (m_pulse > 0) begin
      m_pulse--;
      if (m_pulse == 0) m_hold = 1'b1;
    end else if (m_hold) begin
      if (!m_deb[8]) begin m_hold = 1'b0; m_gap = GAPC; end
    end else begin
      m_gap--;
    end
    m_prev   = m_deb[8];
    exp_p1   = {2'b11, ~u, ~d, ~r, ~l, m_v2, 4'hF, ~m_deb[6], ~m_deb[5], ~fire,
                ~m_deb[7], (m_pulse == 0)};
    exp_busy = !((m_pulse == 0) && !m_hold && (m_gap == 0));
    // A channel changes once DEB consecutive samples disagree with it
    for (int i = 0; i < 10; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin m_deb[i] = !m_deb[i]; m_run[i] = 0; end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1; m_s1 = joystick[9:0];
    m_v2 = m_v1; m_v1 = service_n;
    m_n++;
  endtask

  task automatic tick();
    @(posedge i_clk);
    if (RESETn) model_step();
    else        model_reset();
    #1;
    chk("player1", 32'(PLAYER1), 32'(exp_p1));
    chk("coin_busy", 32'(coin_busy), 32'(exp_busy));
    if (!PLAYER1[0]) lows++;
    if (last0 && !PLAYER1[0]) falls++;
    last0 = PLAYER1[0];
    #1;
  endtask

  initial begin
    int zeros, lat, cnt, tog;
    logic prevb;
    RESETn = 1'b0; joystick = '0; service_n = 1'b1; flip = 1'b0;
    last0 = 1'b1; lows = 0; falls = 0;
    model_reset();

    repeat (3) tick();
    chk("rst_p1", 32'(PLAYER1), 32'hFFFF);
    chk("rst_busy", 32'(coin_busy), 32'd0);
    RESETn = 1'b1;
    repeat (6) tick();
    chk("idle_p1", 32'(PLAYER1), 32'hFFFF);

    // Short glitch on fire must not reach the output
    joystick[4] = 1'b1;
    repeat (3) tick();
    joystick[4] = 1'b0;
    zeros = 0;
    repeat (10) begin tick(); if (!PLAYER1[2]) zeros++; end
    chk("glitch_fire", 32'(zeros), 32'd0);

    joystick[4] = 1'b1;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (!PLAYER1[2] && lat == 0) lat = i;
    end
    joystick[4] = 1'b0;
    chk("fire_latency", 32'(lat), 32'd7);
    repeat (10) tick();
    chk("fire_released", 32'(PLAYER1[2]), 32'd1);

    joystick = 16'h000C;
    repeat (10) tick();
    chk("socd_ud", 32'(PLAYER1[13:12]), 32'd3);
    flip = 1'b1; joystick = 16'h0008;
    repeat (10) tick();
    chk("flip_u", 32'(PLAYER1[13:12]), 32'd2);
    joystick = 16'h0003;
    repeat (10) tick();
    chk("socd_lr", 32'(PLAYER1[11:10]), 32'd3);
    flip = 1'b0; joystick = '0;
    repeat (10) tick();

    // Held coin: one 8-cycle pulse, then re-press lands inside GAP
    lows = 0; falls = 0;
    joystick[8] = 1'b1;
    repeat (40) tick();
    joystick[8] = 1'b0;
    repeat (4) tick();
    chk("busy_hold", 32'(coin_busy), 32'd1);
    chk("coin_lows", 32'(lows), 32'd8);
    chk("coin_falls", 32'(falls), 32'd1);
    falls = 0;
    joystick[8] = 1'b1;
    repeat (20) tick();
    chk("gap_repress", 32'(falls), 32'd0);
    joystick[8] = 1'b0;
    repeat (12) tick();
    chk("busy_idle", 32'(coin_busy), 32'd0);

    // Reset on the third pulse cycle
    joystick[8] = 1'b1;
    cnt = 0;
    while (PLAYER1[0] && cnt < 50) begin tick(); cnt++; end
    chk("pulse_start_in_time", 32'(cnt < 50), 32'd1);
    repeat (2) tick();
    chk("pulse_third", 32'(PLAYER1[0]), 32'd0);
    RESETn = 1'b0; joystick[8] = 1'b0;
    model_reset();
    #1;
    chk("async_rst_coin", 32'(PLAYER1[0]), 32'd1);
    chk("async_rst_busy", 32'(coin_busy), 32'd0);
    repeat (2) tick();
    RESETn = 1'b1;
    repeat (8) tick();
    lows = 0; falls = 0;
    joystick[8] = 1'b1;
    repeat (20) tick();
    joystick[8] = 1'b0;
    repeat (20) tick();
    chk("post_rst_lows", 32'(lows), 32'd8);
    chk("post_rst_falls", 32'(falls), 32'd1);

    // Autofire
    joystick[9] = 1'b1;
    repeat (10) tick();
    tog = 0; zeros = 0; prevb = PLAYER1[2];
    repeat (36) begin
      tick();
      if (PLAYER1[2] != prevb) tog++;
      if (!PLAYER1[2]) zeros++;
      prevb = PLAYER1[2];
    end
`ifdef ASO_AUTOFIRE_EN
    chk("af_toggles", 32'(tog), 32'd12);
    chk("af_duty", 32'(zeros), 32'd18);
`else
    chk("af_ignored", 32'(tog), 32'd0);
    chk("af_fire_high", 32'(zeros), 32'd0);
`endif
    joystick = '0;
    repeat (10) tick();

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < 16; b++)
        if ($urandom_range(7) == 0) joystick[b] = ~joystick[b];
      if ($urandom_range(49) == 0) flip = ~flip;
      if ($urandom_range(19) == 0) service_n = ~service_n;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aso_input_ctrl.md
Name: aso_input_ctrl

Overview:
- Input conditioning stage directly upstream of AlphaMissionCore_Sync.
- Converts raw active-high MiSTer joystick bits and the service-mode status bit into the active-low 16-bit PLAYER1 word the core samples.
- Adds per-button debounce, opposite-direction cancellation, and a coin pulse shaper, so the core sees one clean, fixed-width coin pulse per press.

Parameters:
- DEB_CYCLES, 53600, cycles a raw button must be stable before its debounced state changes (1 ms at 53.6 MHz).
- COIN_PULSE_CYCLES, 5360000, width of the active-low coin pulse (100 ms).
- COIN_GAP_CYCLES, 2680000, minimum coin-inactive time after a pulse before another is accepted (50 ms).
- AUTOFIRE_HALF, 1340000, half-period of the autofire square wave (used only with the optional feature).

Ports:
- i_clk  in  1  system clock, 53.6 MHz.
- RESETn  in  1  asynchronous active-low reset.
- joystick  in  16  raw joystick, active high: [0]R [1]L [2]D [3]U [4]fire [5]missile [6]armor [7]start [8]coin [9]autofire.
- service_n  in  1  active-low service request from OSD status.
- flip  in  1  1 = swap U/D and L/R before output.
- PLAYER1  out  16  active-low word: {2'b11,U,D,R,L,service,4'b1111,armor,missile,fire,start,coin}.
- coin_busy  out  1  high while the coin FSM is outside IDLE.

Behaviour:
- Reset: PLAYER1=16'hFFFF, coin_busy=0, all debounce counters 0, debounced states 0 (released), coin FSM IDLE.
- Input sync: joystick[9:0] and service_n each pass through 2 flops.
- Debounce:
  - 10 independent channels: U, D, L, R, fire, missile, armor, start, coin, autofire.
  - Counter width = $clog2(DEB_CYCLES+1).
  - Synced value equal to debounced state: counter cleared.
  - Otherwise: counter increments. When it reaches DEB_CYCLES-1, the state flips and the counter clears.
  - Any glitch shorter than DEB_CYCLES cycles is fully rejected.
  - service_n is synced only, not debounced.
- Flip: applied after debounce. flip=1 exchanges U<->D and L<->R.
- SOCD cancel: applied after flip. U&D both pressed -> both released. L&R both pressed -> both released.
- Output register:
  - PLAYER1 is registered.
  - Bits 15:14 and 8:5 are constant 1.
  - Button bits are inverted (pressed = 0).
  - Total latency from raw edge to PLAYER1 = 2 sync + DEB_CYCLES + 1 output = DEB_CYCLES+3 cycles.
- Coin FSM (IDLE, PULSE, HOLD, GAP) on the debounced coin, rise = 0->1 edge:
  - IDLE: on rise -> PULSE, load counter with COIN_PULSE_CYCLES-1.
  - PULSE: PLAYER1[0]=0. When counter reaches 0 -> HOLD.
  - HOLD: PLAYER1[0]=1. Waits for debounced coin release, then -> GAP, load COIN_GAP_CYCLES-1.
  - GAP: when counter reaches 0 -> IDLE.
  - A rise during PULSE, HOLD or GAP is ignored, never queued.
  - Holding coin yields exactly one pulse.
- Start/fire/missile/armor/directions are level-through (no shaping).
- coin_busy = (state != IDLE), registered.
- Reset mid-pulse: PLAYER1[0] returns to 1 asynchronously and the FSM goes to IDLE.

Optional Feature:
- Macro: ASO_AUTOFIRE_EN.
- Defined:
  - Free-running counter toggles an autofire phase every AUTOFIRE_HALF cycles.
  - Phase starts at 1 on reset.
  - Effective fire = debounced fire OR (debounced autofire AND phase).
- Undefined: joystick[9] is ignored, no autofire counter is built, and fire = debounced fire.

Decomposition:
- Package aso_input_pkg holds:
  - coin_state_t enum {IDLE, PULSE, HOLD, GAP}.
  - Bit-index localparams for PLAYER1 and joystick fields.
  - PLAYER1 constant-ones mask 16'hC1E0.
- One sub-module: aso_debounce, a single-channel sync-less debouncer with a DEB_CYCLES parameter, instantiated 10 times.

Test Plan:
- All benches override DEB_CYCLES=4, COIN_PULSE_CYCLES=8, COIN_GAP_CYCLES=4, AUTOFIRE_HALF=3.
- Reset: hold RESETn=0 -> PLAYER1=16'hFFFF, coin_busy=0. Release with joystick=0 -> PLAYER1 stays FFFF.
- Debounce: 3-cycle pulse on joystick[4] -> PLAYER1[2] stays 1. 10-cycle press -> PLAYER1[2]=0 exactly 7 cycles after the raw edge.
- SOCD/flip: joystick=16'h000C (U+D) -> PLAYER1[13:12]=2'b11. Then joystick=16'h0008 with flip=1 -> PLAYER1[13]=1, PLAYER1[12]=0.
- Coin:
  - Hold joystick[8] for 40 cycles -> PLAYER1[0]=0 for exactly 8 cycles, single pulse, coin_busy high until GAP ends.
  - Re-press during GAP -> no second pulse.
- Reset mid-pulse: assert RESETn=0 on the 3rd PULSE cycle -> PLAYER1[0]=1 immediately, coin_busy=0. A new press after release yields a full 8-cycle pulse.
- ASO_AUTOFIRE_EN: hold joystick[9] -> PLAYER1[2] toggles with period 6 cycles. Without the macro -> PLAYER1[2] stays 1.
